// File: rtl/ac_actuator_guard.sv
// Relay guard for the AC controller: enforces minimum on/off times, forbids
// direct heat/cool changeover and flags contradictory requests.
module ac_actuator_guard #(
    parameter int unsigned MIN_ON  = 8,
    parameter int unsigned MIN_OFF = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic heating_req,
    input  logic cooling_req,
    output logic heater_on,
    output logic cooler_on,
    output logic lockout,
    output logic fault
);

    localparam logic [15:0] ON_CNT     = 16'(MIN_ON);
    localparam logic [15:0] OFF_RELOAD = 16'(MIN_OFF - 1);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_HEAT,
        ST_COOL
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        heater_q, cooler_q, fault_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_OFF: begin
                // Off-timer must expire before either unit may start.
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 16'd1;
                end else if (heating_req && !cooling_req) begin
                    state_d = ST_HEAT;
                    cnt_d   = 16'd1;
                end else if (cooling_req && !heating_req) begin
                    state_d = ST_COOL;
                    cnt_d   = 16'd1;
                end
            end
            ST_HEAT: begin
                if (cnt_q != ON_CNT) begin
                    cnt_d = cnt_q + 16'd1;
                end else if (!heating_req || cooling_req) begin
                    state_d = ST_OFF;
                    cnt_d   = OFF_RELOAD;
                end
            end
            ST_COOL: begin
                if (cnt_q != ON_CNT) begin
                    cnt_d = cnt_q + 16'd1;
                end else if (!cooling_req || heating_req) begin
                    state_d = ST_OFF;
                    cnt_d   = OFF_RELOAD;
                end
            end
            default: begin
                state_d = ST_OFF;
                cnt_d   = '0;
            end
        endcase
    end

    // Relay drives are registered from the next state so they switch cleanly
    // on the same edge as the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_OFF;
            cnt_q    <= '0;
            heater_q <= 1'b0;
            cooler_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            heater_q <= (state_d == ST_HEAT);
            cooler_q <= (state_d == ST_COOL);
            fault_q  <= heating_req & cooling_req;
        end
    end

    assign heater_on = heater_q;
    assign cooler_on = cooler_q;
    assign fault     = fault_q;
    assign lockout   = (state_q == ST_OFF) && (cnt_q != '0);

endmodule
